// File: rtl/softmax_pkg.sv
// Shared Q4.12 constants and FSM state type for the softmax datapath blocks.
// The log2 approximator imports this package for its encoding and exponent width.
package softmax_pkg;

  localparam int Q_DATA_W = 16;
  localparam int Q_FRAC_W = 12;
  localparam int Q_INT_W  = Q_DATA_W - Q_FRAC_W;
  // Internal exponent range is -12..+2; 5 signed bits hold it with margin.
  localparam int EXP_W    = 5;

  localparam logic [Q_DATA_W-1:0] Q_ONE = 16'h1000;
  localparam logic [Q_DATA_W-1:0] Q_MIN = 16'h8000;

  localparam logic signed [EXP_W-1:0] E_ONE = 5'sd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/log2_norm_step.sv
// One normalisation step: move the leading one of m toward bit FRAC_W,
// tracking the binary exponent. Purely combinational.
module log2_norm_step
  import softmax_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic [DATA_W-1:0]       m_i,
  input  logic signed [EXP_W-1:0] e_i,
  output logic [DATA_W-1:0]       m_o,
  output logic signed [EXP_W-1:0] e_o,
  output logic                    norm_o
);

  always_comb begin
    m_o    = m_i;
    e_o    = e_i;
    norm_o = 1'b0;
    if (|m_i[DATA_W-1:FRAC_W+1]) begin
      // Logical right shift; the dropped LSB is truncated, never rounded.
      m_o = m_i >> 1;
      e_o = e_i + E_ONE;
    end else if (!m_i[FRAC_W]) begin
      m_o = m_i << 1;
      e_o = e_i - E_ONE;
    end else begin
      norm_o = 1'b1;
    end
  end

endmodule

// File: rtl/log2_approx_seq.sv
// Sequential log2 approximator, Q4.12 in and out: normalise x = 2^e*(1+f)
// one shift per cycle, then report e + f. One transaction in flight.
module log2_approx_seq
  import softmax_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] log2_x,
  output logic              err,
  output state_e            dbg_state
);

  localparam int INT_W = DATA_W - FRAC_W;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds data stable while valid is high and ready low.

  state_e                  state_q;
  logic [DATA_W-1:0]       m_q;
  logic signed [EXP_W-1:0] e_q;
  logic [DATA_W-1:0]       log2_q;
  logic                    err_q;
  logic                    out_valid_q;

  logic [DATA_W-1:0]       m_d;
  logic signed [EXP_W-1:0] e_d;
  logic                    norm;
  logic                    bad_in;

  log2_norm_step #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_step (
    .m_i   (m_q),
    .e_i   (e_q),
    .m_o   (m_d),
    .e_o   (e_d),
    .norm_o(norm)
  );

  assign bad_in = ($signed(in_x) <= 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      log2_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (bad_in) begin
              log2_q      <= Q_MIN;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              m_q     <= in_x;
              e_q     <= '0;
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (norm) begin
            log2_q      <= {e_q[INT_W-1:0], m_q[FRAC_W-1:0]};
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            m_q <= m_d;
            e_q <= e_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign log2_x    = log2_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_log2_approx_seq.sv
// Directed and randomized bench for log2_approx_seq against an arithmetic
// reference built from leading-one position and mantissa extraction.
module tb_log2_approx_seq;
  import softmax_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] log2_x;
  logic        err;
  state_e      dbg_state;

  int total;
  int bad;
  logic [16:0] exp_q[$];

  log2_approx_seq #(
    .DATA_W(16),
    .FRAC_W(12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .log2_x   (log2_x),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: log2(x/4096) = p-12 + fraction, p = leading-one position.
  // Result packs {err, log2_x}; lat is cycles from accept to out_valid.
  function automatic logic [16:0] ref_log2(input logic [15:0] x, output int lat);
    int xi, p, e, f;
    xi = int'(x);
    if ($signed(x) <= 0) begin
      lat = 1;
      return {1'b1, Q_MIN};
    end
    p = 0;
    for (int b = 0; b < 15; b++) if (xi >= (1 << b)) p = b;
    e = p - 12;
    f = (p >= 12) ? (xi >>> (p - 12)) : (xi << (12 - p));
    lat = 2 + ((e < 0) ? -e : e);
    return {1'b0, 4'(e & 15), 12'(f & 'hFFF)};
  endfunction

  // Driver: one transaction with bp cycles of backpressure once out_valid rises.
  task automatic do_txn(input logic [15:0] x, input int bp);
    int lat, n;
    logic [16:0] exp, got;
    exp = ref_log2(x, lat);
    exp_q.push_back(exp);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_x     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 16'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk($sformatf("latency_%04h", x), 32'(n), 32'(lat));
    got = {err, log2_x};
    chk($sformatf("result_%04h", x), 32'(got), 32'(exp_q.pop_front()));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_stable", 32'({err, log2_x}), 32'(got));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        in_x     = 16'h1000;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic quiet;
    logic [15:0] rx;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 16'h0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_log2", 32'(log2_x), 32'h0000);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Directed values: powers of two, mid-mantissa, extremes, bad inputs
    do_txn(16'h1000, 0);
    chk("one_is_zero", 32'(log2_x), 32'h0000);
    do_txn(16'h4000, 0);
    do_txn(16'h0800, 0);
    do_txn(16'h3000, 0);
    do_txn(16'h0001, 0);
    do_txn(16'h7FFF, 0);
    do_txn(16'h0000, 0);
    do_txn(16'h9000, 0);
    do_txn(16'h2000, 5);
    do_txn(16'h0000, 5);

    // Reset during normalisation of the slowest operand
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(in_ready), 32'd1);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("midrst_no_output", 32'(quiet), 32'd1);

    // Round trip over [1.0, 2.0): result is the bare mantissa
    for (int i = 0; i < 16; i++) begin
      rx = 16'($urandom_range(16'h1FFF, 16'h1000));
      do_txn(rx, 0);
      chk("round_trip", 32'(log2_x), 32'(rx - Q_ONE));
    end

    // Random full-range operands, including non-positive ones
    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      do_txn(rx, $urandom_range(2, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
